// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO in front of a UART transmitter. Bytes written by a
// producer are buffered and launched one at a time, paced by the transmitter's
// active/done status so the producer never has to track serial timing.
//
// Transmitter handshake: a launch is a single-cycle o_Tx_DV pulse with
// o_Tx_Byte held stable until the next launch. A launch is only issued from
// S_IDLE while i_Tx_Active=0 and i_Tx_Done=0. After launching, the feeder waits
// for i_Tx_Active to rise, then for i_Tx_Done to rise, then for i_Tx_Done to
// fall again, so a multi-cycle done flag never triggers a second launch.
module uart_tx_feeder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    input  logic              i_Wr_DV,
    input  logic [7:0]        i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done,
    output logic              o_Busy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ACT  = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_WAIT_CLR  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    state_t            state_q;
    logic              tx_dv_q;
    logic [7:0]        tx_byte_q;

    logic full;
    logic empty;
    logic pop;
    logic push;

    // Status comes only from registered count, never from the write strobe.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign pop  = (state_q == S_IDLE) && !empty && !i_Tx_Active && !i_Tx_Done;
    assign push = i_Wr_DV && (!full || pop);

    // Next-state for pointers, occupancy and the drop indicator.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = i_Wr_DV && !push;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is left untouched by reset; only the pointers define validity.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_Wr_Byte;
        end
    end

    // Pointer, count and overflow registers.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Launch sequencer: pops one byte, then tracks the transmitter through
    // active, done, and done-cleared before returning to idle.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state_q   <= S_IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            tx_dv_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        tx_byte_q <= mem_q[rd_ptr_q];
                        tx_dv_q   <= 1'b1;
                        state_q   <= S_WAIT_ACT;
                    end
                end
                S_WAIT_ACT: begin
                    if (i_Tx_Active) begin
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        state_q <= S_WAIT_CLR;
                    end
                end
                S_WAIT_CLR: begin
                    if (!i_Tx_Done) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_Full     = full;
    assign o_Empty    = empty;
    assign o_Count    = count_q;
    assign o_Overflow = overflow_q;
    assign o_Tx_DV    = tx_dv_q;
    assign o_Tx_Byte  = tx_byte_q;
    assign o_Busy     = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed bench with a behavioural UART transmitter model
// (4 clocks per bit, done held for two cycles), a serial-line decoder, and a
// scoreboard that pairs each launch pulse with the next expected byte.
module tb_uart_tx_feeder;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CPB    = 4;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_dv = 1'b0;
    logic [7:0]        wr_byte = 8'h00;
    logic              full, empty, ovf, tx_dv, busy;
    logic [ADDR_W:0]   cnt;
    logic [7:0]        tx_byte;
    logic              tx_active, tx_done;
    logic              hold_active = 1'b0;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_Clock     (clk),
        .i_Reset_n   (rst_n),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Byte   (wr_byte),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (cnt),
        .o_Overflow  (ovf),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done),
        .o_Busy      (busy)
    );

    // ---------------- transmitter model (never reset) ----------------
    logic       m_active = 1'b0;
    logic       m_done = 1'b0;
    logic       m_serial = 1'b1;
    logic [9:0] m_frame = '0;
    logic [1:0] m_st = 2'd0;
    int         m_cnt = 0;
    int         m_bits = 0;
    int         m_dcnt = 0;

    assign tx_active = m_active | hold_active;
    assign tx_done   = m_done;

    always @(posedge clk) begin
        case (m_st)
            2'd0: begin
                if (tx_dv) begin
                    m_frame  <= {1'b1, tx_byte, 1'b0};
                    m_serial <= 1'b0;
                    m_active <= 1'b1;
                    m_cnt    <= 0;
                    m_bits   <= 9;
                    m_st     <= 2'd1;
                end
            end
            2'd1: begin
                if (m_cnt == CPB - 1) begin
                    m_cnt <= 0;
                    if (m_bits == 0) begin
                        m_active <= 1'b0;
                        m_done   <= 1'b1;
                        m_dcnt   <= 1;
                        m_st     <= 2'd2;
                    end else begin
                        m_frame  <= m_frame >> 1;
                        m_serial <= m_frame[1];
                        m_bits   <= m_bits - 1;
                    end
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
            default: begin
                if (m_dcnt == 0) begin
                    m_done <= 1'b0;
                    m_st   <= 2'd0;
                end else begin
                    m_dcnt <= m_dcnt - 1;
                end
            end
        endcase
    end

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] ser_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         dv_count = 0;
    int         peak = 0;
    logic       dec_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- launch monitor ----------------
    logic prev_dv = 1'b0;
    logic prev_active = 1'b0;
    logic prev_done = 1'b0;
    logic launched = 1'b0;
    logic backlog = 1'b0;
    int   fall_cyc = 0;

    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_n) begin
            launched = 1'b0;
            backlog  = 1'b0;
        end
        if (tx_dv) begin
            dv_count++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL dv_unexpected: got byte %0h expected no launch", tx_byte);
            end else begin
                e = exp_q.pop_front();
                ser_q.push_back(e);
                if (tx_byte !== e) begin
                    n_fail++;
                    $display("FAIL tx_byte: got %0h expected %0h", tx_byte, e);
                end
            end
            check("dv_single_cycle", int'(prev_dv), 0);
            check("launch_guard", int'({prev_active, prev_done}), 0);
            if (backlog) check("launch_gap", cyc - fall_cyc, 2);
            launched = 1'b1;
            backlog  = 1'b0;
        end
        if (prev_done && !tx_done) begin
            fall_cyc = cyc;
            backlog  = launched && (cnt != 0);
        end
        if (int'(cnt) > peak) peak = int'(cnt);
        prev_dv     = tx_dv;
        prev_active = tx_active;
        prev_done   = tx_done;
    end

    // ---------------- serial decoder ----------------
    initial begin
        logic [7:0] rx;
        logic       stop_b;
        logic [7:0] e;
        forever begin
            @(negedge m_serial);
            dec_busy = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            check("serial_start", int'(m_serial), 0);
            for (int b = 0; b < 8; b++) begin
                repeat (CPB) @(posedge clk);
                #1;
                rx[b] = m_serial;
            end
            repeat (CPB) @(posedge clk);
            #1;
            stop_b = m_serial;
            check("serial_stop", int'(stop_b), 1);
            n_tests++;
            if (ser_q.size() == 0) begin
                n_fail++;
                $display("FAIL serial_unexpected: got %0h expected none", rx);
            end else begin
                e = ser_q.pop_front();
                if (rx !== e) begin
                    n_fail++;
                    $display("FAIL serial_byte: got %0h expected %0h", rx, e);
                end
            end
            dec_busy = 1'b0;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            @(negedge clk);
            if (!busy && !m_active && !m_done && !dec_busy && exp_q.size() == 0 &&
                ser_q.size() == 0)
                ok = 1'b1;
        end
        check(name, int'(ok), 1);
    endtask

    logic [7:0] hello [5];

    // ---------------- directed stimulus ----------------
    initial begin
        int   dv0;
        logic seen_done;
        logic fell;

        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

        // Reset, then idle for 20 cycles.
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_dv) check("idle_no_dv", int'(tx_dv), 0);
        end
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(cnt), 0);
        check("rst_tx_byte", int'(tx_byte), 8'h00);
        check("rst_overflow", int'(ovf), 0);

        // Single byte: pulse in the cycle after the second edge.
        tick();
        wr_dv = 1'b1; wr_byte = 8'hA5; exp_q.push_back(8'hA5);
        tick();
        wr_dv = 1'b0;
        @(negedge clk);
        check("single_no_bypass", int'(tx_dv), 0);
        check("single_count", int'(cnt), 1);
        tick();
        @(negedge clk);
        check("single_dv", int'(tx_dv), 1);
        check("single_byte", int'(tx_byte), 8'hA5);
        seen_done = 1'b0;
        fell = 1'b0;
        for (int i = 0; i < 200 && !fell; i++) begin
            @(negedge clk);
            if (tx_done) seen_done = 1'b1;
            if (!busy) fell = 1'b1;
        end
        check("single_busy_fell", int'(fell), 1);
        check("single_done_seen", int'(seen_done), 1);
        check("single_done_low_at_idle", int'(tx_done), 0);
        wait_idle("single_drain", 200);

        // HELLO burst on consecutive cycles.
        peak = 0;
        dv0 = dv_count;
        for (int i = 0; i < 5; i++) begin
            tick();
            wr_dv = 1'b1; wr_byte = hello[i]; exp_q.push_back(hello[i]);
        end
        tick();
        wr_dv = 1'b0;
        wait_idle("hello_drain", 1000);
        check("hello_peak_count", peak, 4);
        check("hello_pulses", dv_count - dv0, 5);

        // 17 writes with the transmitter held active.
        tick();
        hold_active = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            wr_dv = 1'b1;
            wr_byte = (i < 16) ? 8'(8'h10 + i) : 8'hEE;
            if (i < 16) exp_q.push_back(wr_byte);
            if (i == 16) begin
                @(negedge clk);
                check("fill_full", int'(full), 1);
                check("fill_count", int'(cnt), 16);
                check("fill_no_ovf", int'(ovf), 0);
            end
        end
        tick();
        wr_dv = 1'b0;
        @(negedge clk);
        check("drop_ovf", int'(ovf), 1);
        check("drop_count", int'(cnt), 16);
        check("drop_full", int'(full), 1);
        tick();
        @(negedge clk);
        check("drop_ovf_pulse", int'(ovf), 0);
        hold_active = 1'b0;
        wait_idle("wrap_drain", 3000);

        // Full FIFO: write coincides with the first pop.
        tick();
        hold_active = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            wr_dv = 1'b1; wr_byte = 8'(8'h60 + i); exp_q.push_back(wr_byte);
        end
        tick();
        hold_active = 1'b0;
        wr_dv = 1'b1; wr_byte = 8'h7F; exp_q.push_back(8'h7F);
        tick();
        wr_dv = 1'b0;
        @(negedge clk);
        check("pushpop_count", int'(cnt), 16);
        check("pushpop_no_ovf", int'(ovf), 0);
        check("pushpop_dv", int'(tx_dv), 1);
        wait_idle("pushpop_drain", 3000);

        // Reset mid-byte with three bytes queued.
        for (int i = 0; i < 4; i++) begin
            tick();
            wr_dv = 1'b1; wr_byte = 8'(8'h91 + i); exp_q.push_back(wr_byte);
        end
        tick();
        wr_dv = 1'b0;
        repeat (12) tick();
        @(negedge clk);
        check("pre_rst_count", int'(cnt), 3);
        check("pre_rst_tx_active", int'(m_active), 1);
        tick();
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        rst_n = 1'b1;
        wr_dv = 1'b1; wr_byte = 8'h3C; exp_q.push_back(8'h3C);
        @(negedge clk);
        check("midrst_count", int'(cnt), 0);
        check("midrst_dv", int'(tx_dv), 0);
        check("midrst_empty", int'(empty), 1);
        check("midrst_busy", int'(busy), 0);
        tick();
        wr_dv = 1'b0;
        @(negedge clk);
        check("midrst_waits_for_tx", int'(tx_dv), 0);
        wait_idle("midrst_drain", 1000);

        check("final_exp_empty", exp_q.size(), 0);
        check("final_ser_empty", ser_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
